// File: rtl/ser_tx_arb_pkg.sv
// Shared types and constants for the serial transmit arbiter.
package ser_tx_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_CHID = 2'd2,
    ST_DATA = 2'd3
  } state_e;

  localparam logic [7:0] HDR_BYTE_DEF = 8'hF0;

  // Channel-id byte: continuation flag in the MSB, channel index in the low bits.
  localparam int unsigned CHID_CONT_BIT = 7;
  localparam int unsigned CHID_IDX_W    = 3;

  function automatic logic [7:0] chid_byte(input logic cont, input logic [CHID_IDX_W-1:0] idx);
    logic [7:0] b;
    b                   = '0;
    b[CHID_CONT_BIT]    = cont;
    b[CHID_IDX_W-1:0]   = idx;
    return b;
  endfunction

endpackage

// File: rtl/ser_tx_arb_if.sv
// Channel-side and serializer-side signals of the arbiter.
interface ser_tx_arb_if #(
  parameter int unsigned N_CH = 8
);

  logic [N_CH-1:0]   ch_req;
  logic [8*N_CH-1:0] ch_data;
  logic [N_CH-1:0]   ch_last;
  logic [N_CH-1:0]   ch_ack;
  logic              serial_busy;
  logic              serial_en;
  logic [7:0]        serial_tx;
  logic [2:0]        grant;
  logic              frame_active;

  modport master (
    input  ch_req, ch_data, ch_last, serial_busy,
    output ch_ack, serial_en, serial_tx, grant, frame_active
  );

  modport slave (
    output ch_req, ch_data, ch_last, serial_busy,
    input  ch_ack, serial_en, serial_tx, grant, frame_active
  );

endinterface

// File: rtl/ser_tx_arb_rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr.
module rr_pick #(
  parameter int unsigned N_CH = 8
) (
  input  logic [N_CH-1:0] req,
  input  logic [2:0]      ptr,
  output logic            valid,
  output logic [2:0]      idx
);

  logic [7:0] req_pad;
  logic [3:0] sum;
  logic [2:0] cand;

  // Scan channels ptr, ptr+1, ... (mod N_CH) and keep the first one requesting.
  always_comb begin
    req_pad              = '0;
    req_pad[N_CH-1:0]    = req;
    valid                = 1'b0;
    idx                  = '0;
    sum                  = '0;
    cand                 = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      sum  = {1'b0, ptr} + 4'(i);
      cand = (sum >= 4'(N_CH)) ? 3'(sum - 4'(N_CH)) : sum[2:0];
      if (!valid && req_pad[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/ser_tx_arb.sv
// Frames bytes from N_CH channels onto one serializer: HDR, CHID, then data bytes.
module ser_tx_arb
  import ser_tx_arb_pkg::*;
#(
  parameter int unsigned N_CH      = 8,
  parameter logic [7:0]  HDR_BYTE  = HDR_BYTE_DEF,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic            clk,
  input  logic            rst,
  ser_tx_arb_if.master    bus
);

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] grant_q, grant_d;
  logic [7:0] burst_cnt_q, burst_cnt_d;
  logic [7:0] cont_q, cont_d;
  logic       guard_q, guard_d;

  logic [7:0]  req_pad, last_pad, ack_pad;
  logic [63:0] data_pad;
  logic        pick_valid;
  logic [2:0]  pick_idx;
  logic        ready;
  logic        end_frame;
  logic [7:0]  burst_nxt;
  logic        serial_en_c;
  logic [7:0]  serial_tx_c;

  rr_pick #(.N_CH(N_CH)) u_rr_pick (
    .req   (bus.ch_req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Widen channel vectors to 8 lanes so a 3-bit grant indexes them directly.
  always_comb begin
    req_pad                  = '0;
    last_pad                 = '0;
    data_pad                 = '0;
    req_pad[N_CH-1:0]        = bus.ch_req;
    last_pad[N_CH-1:0]       = bus.ch_last;
    data_pad[8*N_CH-1:0]     = bus.ch_data;
  end

  // Next-state and strobe generation.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    burst_cnt_d = burst_cnt_q;
    cont_d      = cont_q;
    serial_en_c = 1'b0;
    serial_tx_c = '0;
    ack_pad     = '0;
    end_frame   = 1'b0;
    ready       = !bus.serial_busy && !guard_q;
    burst_nxt   = burst_cnt_q + 8'd1;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (ready) begin
          serial_en_c = 1'b1;
          serial_tx_c = HDR_BYTE;
          state_d     = ST_CHID;
        end
      end
      ST_CHID: begin
        if (ready) begin
          serial_en_c = 1'b1;
          serial_tx_c = chid_byte(cont_q[grant_q], grant_q);
          burst_cnt_d = '0;
          state_d     = ST_DATA;
        end
      end
      ST_DATA: begin
        if (ready && req_pad[grant_q]) begin
          serial_en_c       = 1'b1;
          serial_tx_c       = data_pad[{grant_q, 3'b000} +: 8];
          ack_pad[grant_q]  = 1'b1;
          burst_cnt_d       = burst_nxt;
          // Record end takes priority over the burst limit for the continuation flag.
          if (last_pad[grant_q]) begin
            cont_d[grant_q] = 1'b0;
            end_frame       = 1'b1;
          end else if (burst_nxt == 8'(MAX_BURST)) begin
            cont_d[grant_q] = 1'b1;
            end_frame       = 1'b1;
          end
          if (end_frame) begin
            state_d = ST_IDLE;
            ptr_d   = (grant_q == 3'(N_CH - 1)) ? 3'd0 : grant_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    guard_d = serial_en_c;
  end

  // Outputs are forced quiet while reset is held so an abandoned frame emits nothing.
  always_comb begin
    bus.serial_en    = 1'b0;
    bus.serial_tx    = '0;
    bus.ch_ack       = '0;
    bus.frame_active = 1'b0;
    bus.grant        = grant_q;
    if (!rst) begin
      bus.serial_en    = serial_en_c;
      bus.serial_tx    = serial_tx_c;
      bus.ch_ack       = ack_pad[N_CH-1:0];
      bus.frame_active = (state_q != ST_IDLE);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      burst_cnt_q <= '0;
      cont_q      <= '0;
      guard_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      burst_cnt_q <= burst_cnt_d;
      cont_q      <= cont_d;
      guard_q     <= guard_d;
    end
  end

endmodule

// File: tb/tb_ser_tx_arb.sv
// Self-checking bench for ser_tx_arb: directed vector table, corner sequences, random traffic.
`timescale 1ns/1ps
module tb_ser_tx_arb;

  localparam int unsigned NCH  = 8;
  localparam int unsigned MAXB = 4;
  localparam logic [7:0]  HDR  = 8'hF0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ser_tx_arb_if #(.N_CH(NCH)) bus ();

  ser_tx_arb #(.N_CH(NCH), .HDR_BYTE(HDR), .MAX_BURST(MAXB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0]     chq [NCH][$];
  logic [8:0]     mq  [NCH][$];
  logic [NCH-1:0] drop;
  logic [NCH-1:0] pop_pend;
  logic           busy_force;
  int unsigned    busy_pct;
  logic           prev_en;
  logic [7:0]     cap_b[$];
  logic [2:0]     cap_g[$];
  logic [7:0]     exp_q[$];

  typedef struct {
    int         ch;
    int         len;
    logic [7:0] d0;
    logic [7:0] stp;
    logic [7:0] chid1;
    int         n1;
    logic [7:0] chid2;
    int         n2;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    logic [8:0] e;
    for (int i = 0; i < NCH; i++) begin
      if (chq[i].size() > 0 && !drop[i]) begin
        e                   = chq[i][0];
        bus.ch_req[i]       = 1'b1;
        bus.ch_data[8*i +: 8] = e[7:0];
        bus.ch_last[i]      = e[8];
      end else begin
        bus.ch_req[i]       = 1'b0;
        bus.ch_data[8*i +: 8] = 8'h00;
        bus.ch_last[i]      = 1'b0;
      end
    end
    bus.serial_busy = busy_force || ($urandom_range(0, 99) < busy_pct);
  endtask

  task automatic sample();
    logic [8:0] e;
    if (!bus.serial_en) check("tx_zero_without_en", 32'(bus.serial_tx), 32'h0);
    if (bus.ch_ack != '0) begin
      check("ack_onehot", 32'($onehot0(bus.ch_ack)), 32'h1);
      check("ack_needs_en", 32'(bus.serial_en), 32'h1);
    end
    if (bus.serial_en) begin
      check("en_while_busy", 32'(bus.serial_busy), 32'h0);
      check("en_guard_cycle", 32'(prev_en), 32'h0);
      cap_b.push_back(bus.serial_tx);
      cap_g.push_back(bus.grant);
    end
    for (int i = 0; i < NCH; i++) begin
      if (bus.ch_ack[i]) begin
        check("ack_grant", 32'(bus.grant), 32'(i));
        if (chq[i].size() > 0) begin
          e = chq[i][0];
          check("ack_byte", 32'(bus.serial_tx), 32'(e[7:0]));
        end else begin
          check("ack_on_empty_channel", 32'(chq[i].size()), 32'h1);
        end
      end
    end
    pop_pend = bus.ch_ack;
    prev_en  = bus.serial_en;
  endtask

  // One clock: sample outputs on the falling edge, then pop acked bytes and drive after the rising edge.
  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++)
      if (pop_pend[i] && chq[i].size() > 0) void'(chq[i].pop_front());
    drive();
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int c;
    c = 0;
    while (cap_b.size() < n && c < budget) begin
      step();
      c++;
    end
    if (cap_b.size() < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL byte_wait_timeout: got %0d bytes, required %0d", cap_b.size(), n);
    end
  endtask

  task automatic cmp_stream(input string tag, input int base);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (base + k < cap_b.size()) begin
        check(tag, 32'(cap_b[base + k]), 32'(exp_q[k]));
      end else begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s: byte %0d missing, required 0x%0h", tag, k, exp_q[k]);
      end
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < NCH; i++) chq[i].delete();
    drop       = '0;
    busy_force = 1'b0;
    rst        = 1'b1;
    drive();
    step();
    rst = 1'b0;
    drive();
  endtask

  task automatic load_rec(input int ch, input int len, input logic [7:0] d0, input logic [7:0] stp);
    for (int k = 0; k < len; k++)
      chq[ch].push_back({(k == len - 1), 8'(d0 + 8'(k) * stp)});
  endtask

  // Reference: whole frames from round-robin order and record/burst rules, independent of timing.
  task automatic model_stream();
    int             p, g, n;
    bit             found;
    logic [NCH-1:0] cont;
    logic [8:0]     e;
    exp_q.delete();
    p    = 0;
    cont = '0;
    while (1) begin
      found = 0;
      g     = 0;
      for (int k = 0; k < NCH; k++) begin
        if (!found && mq[(p + k) % NCH].size() > 0) begin
          found = 1;
          g     = (p + k) % NCH;
        end
      end
      if (!found) break;
      exp_q.push_back(HDR);
      exp_q.push_back({cont[g], 4'b0000, 3'(g)});
      n = 0;
      do begin
        e = mq[g].pop_front();
        exp_q.push_back(e[7:0]);
        n++;
      end while (!e[8] && n < MAXB);
      cont[g] = !e[8];
      p = (g + 1) % NCH;
    end
  endtask

  initial begin
    int         base, base2, tot, len;
    logic [7:0] b;
    logic [8:0] e;

    tbl[0] = '{ch:2, len:3, d0:8'h11, stp:8'h11, chid1:8'h02, n1:3, chid2:8'h00, n2:0};
    tbl[1] = '{ch:1, len:6, d0:8'hA0, stp:8'h01, chid1:8'h01, n1:4, chid2:8'h81, n2:2};
    tbl[2] = '{ch:7, len:4, d0:8'h40, stp:8'h03, chid1:8'h07, n1:4, chid2:8'h00, n2:0};
    tbl[3] = '{ch:7, len:1, d0:8'h5A, stp:8'h01, chid1:8'h07, n1:1, chid2:8'h00, n2:0};
    tbl[4] = '{ch:3, len:8, d0:8'h80, stp:8'h01, chid1:8'h03, n1:4, chid2:8'h83, n2:4};
    tbl[5] = '{ch:3, len:1, d0:8'hC3, stp:8'h01, chid1:8'h03, n1:1, chid2:8'h00, n2:0};
    tbl[6] = '{ch:0, len:2, d0:8'hFF, stp:8'h01, chid1:8'h00, n1:2, chid2:8'h00, n2:0};

    rst        = 1'b1;
    drop       = '0;
    pop_pend   = '0;
    busy_force = 1'b0;
    busy_pct   = 0;
    prev_en    = 1'b0;
    drive();
    @(posedge clk);
    #1;
    do_reset();

    check("reset_serial_en", 32'(bus.serial_en), 32'h0);
    check("reset_serial_tx", 32'(bus.serial_tx), 32'h0);
    check("reset_ch_ack", 32'(bus.ch_ack), 32'h0);
    check("reset_frame_active", 32'(bus.frame_active), 32'h0);
    check("reset_grant", 32'(bus.grant), 32'h0);

    // Single-channel records through the vector table, with light random backpressure.
    busy_pct = 30;
    for (int t = 0; t < 7; t++) begin
      base = cap_b.size();
      load_rec(tbl[t].ch, tbl[t].len, tbl[t].d0, tbl[t].stp);
      drive();
      exp_q.delete();
      exp_q.push_back(HDR);
      exp_q.push_back(tbl[t].chid1);
      for (int k = 0; k < tbl[t].n1; k++) exp_q.push_back(8'(tbl[t].d0 + 8'(k) * tbl[t].stp));
      if (tbl[t].n2 > 0) begin
        exp_q.push_back(HDR);
        exp_q.push_back(tbl[t].chid2);
        for (int k = 0; k < tbl[t].n2; k++)
          exp_q.push_back(8'(tbl[t].d0 + 8'(tbl[t].n1 + k) * tbl[t].stp));
      end
      tot = exp_q.size();
      wait_bytes(base + tot, 400);
      cmp_stream("table_byte", base);
      for (int k = 0; k < tot; k++)
        if (base + k < cap_g.size()) check("table_grant", 32'(cap_g[base + k]), 32'(tbl[t].ch));
      step();
      step();
      check("table_no_extra_bytes", 32'(cap_b.size()), 32'(base + tot));
      check("table_back_to_idle", 32'(bus.frame_active), 32'h0);
      check("table_queue_drained", 32'(chq[tbl[t].ch].size()), 32'h0);
    end

    // Round-robin between ch0 and ch5 with continuous 1-byte records.
    do_reset();
    busy_pct = 0;
    base     = cap_b.size();
    for (int k = 0; k < 4; k++) begin
      chq[0].push_back({1'b1, 8'(8'h10 + k)});
      chq[5].push_back({1'b1, 8'(8'h50 + k)});
    end
    drive();
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(HDR); exp_q.push_back(8'h00); exp_q.push_back(8'(8'h10 + k));
      exp_q.push_back(HDR); exp_q.push_back(8'h05); exp_q.push_back(8'(8'h50 + k));
    end
    wait_bytes(base + 24, 400);
    cmp_stream("rr_byte", base);
    for (int f = 0; f < 8; f++)
      if (base + 3*f + 1 < cap_g.size())
        check("rr_grant", 32'(cap_g[base + 3*f + 1]), (f % 2 == 0) ? 32'd0 : 32'd5);

    // Backpressure: busy held for 5 cycles in DATA.
    base = cap_b.size();
    load_rec(4, 4, 8'h61, 8'h01);
    drive();
    wait_bytes(base + 3, 100);
    busy_force = 1'b1;
    drive();
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_no_strobe", 32'(bus.serial_en), 32'h0);
    end
    check("bp_no_bytes", 32'(cap_b.size()), 32'(base + 3));
    check("bp_no_pops", 32'(chq[4].size()), 32'h3);
    busy_force = 1'b0;
    drive();
    wait_bytes(base + 6, 100);
    exp_q.delete();
    exp_q.push_back(HDR); exp_q.push_back(8'h04);
    for (int k = 0; k < 4; k++) exp_q.push_back(8'(8'h61 + k));
    cmp_stream("bp_byte", base);

    // Underrun: ch3 withdraws its request for 10 cycles mid-record.
    base = cap_b.size();
    load_rec(3, 4, 8'h71, 8'h01);
    drive();
    wait_bytes(base + 4, 100);
    drop[3] = 1'b1;
    drive();
    for (int k = 0; k < 10; k++) begin
      step();
      check("ur_frame_active", 32'(bus.frame_active), 32'h1);
      check("ur_grant", 32'(bus.grant), 32'h3);
    end
    check("ur_no_bytes", 32'(cap_b.size()), 32'(base + 4));
    drop[3] = 1'b0;
    drive();
    wait_bytes(base + 6, 100);
    step();
    step();
    exp_q.delete();
    exp_q.push_back(HDR); exp_q.push_back(8'h03);
    for (int k = 0; k < 4; k++) exp_q.push_back(8'(8'h71 + k));
    cmp_stream("ur_byte", base);
    check("ur_no_new_header", 32'(cap_b.size()), 32'(base + 6));

    // Reset right after the CHID of a continuation frame.
    base = cap_b.size();
    load_rec(6, 6, 8'h91, 8'h01);
    drive();
    wait_bytes(base + 8, 200);
    if (base + 7 < cap_b.size()) check("rm_cont_chid", 32'(cap_b[base + 7]), 32'h86);
    rst = 1'b1;
    drive();
    #1;
    check("rm_rst_serial_en", 32'(bus.serial_en), 32'h0);
    check("rm_rst_serial_tx", 32'(bus.serial_tx), 32'h0);
    check("rm_rst_ch_ack", 32'(bus.ch_ack), 32'h0);
    check("rm_rst_frame_active", 32'(bus.frame_active), 32'h0);
    step();
    rst = 1'b0;
    chq[6].delete();
    chq[0].push_back({1'b1, 8'hA1});
    chq[6].push_back({1'b1, 8'hB1});
    drive();
    #1;
    check("rm_after_frame_active", 32'(bus.frame_active), 32'h0);
    check("rm_after_grant", 32'(bus.grant), 32'h0);
    check("rm_after_serial_en", 32'(bus.serial_en), 32'h0);
    check("rm_no_replay", 32'(cap_b.size()), 32'(base + 8));
    base2 = cap_b.size();
    wait_bytes(base2 + 6, 200);
    exp_q.delete();
    exp_q.push_back(HDR); exp_q.push_back(8'h00); exp_q.push_back(8'hA1);
    exp_q.push_back(HDR); exp_q.push_back(8'h06); exp_q.push_back(8'hB1);
    cmp_stream("rm_byte", base2);

    // Random records on random channels against the frame-level reference.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      busy_pct = 30;
      for (int i = 0; i < NCH; i++) mq[i].delete();
      for (int rr = 0; rr < 2; rr++) begin
        for (int i = 0; i < NCH; i++) begin
          if ($urandom_range(0, 1) == 1) begin
            len = int'($urandom_range(1, 9));
            for (int k = 0; k < len; k++) begin
              b = 8'($urandom_range(0, 255));
              e = {(k == len - 1), b};
              chq[i].push_back(e);
              mq[i].push_back(e);
            end
          end
        end
      end
      drive();
      model_stream();
      base = cap_b.size();
      tot  = exp_q.size();
      wait_bytes(base + tot, 12 * tot + 100);
      step();
      step();
      cmp_stream("rand_byte", base);
      check("rand_byte_count", 32'(cap_b.size()), 32'(base + tot));
      check("rand_idle", 32'(bus.frame_active), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
